// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL register-write scheduler: register-range bases,
// FSM state encoding, update-strobe bit positions and the address decoder.
package jtopl_pkg;

    localparam logic [7:0] ADDR_MULT   = 8'h20;
    localparam logic [7:0] ADDR_KSL_TL = 8'h40;
    localparam logic [7:0] ADDR_AR_DR  = 8'h60;
    localparam logic [7:0] ADDR_SL_RR  = 8'h80;
    localparam logic [7:0] ADDR_FNUMLO = 8'hA0;
    localparam logic [7:0] ADDR_FNUMHI = 8'hB0;
    localparam logic [7:0] ADDR_RHY    = 8'hBD;
    localparam logic [7:0] ADDR_FBCON  = 8'hC0;
    localparam logic [7:0] ADDR_WAV    = 8'hE0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int STB_MULT   = 0;
    localparam int STB_KSL_TL = 1;
    localparam int STB_AR_DR  = 2;
    localparam int STB_SL_RR  = 3;
    localparam int STB_WAV    = 4;
    localparam int STB_FNUMLO = 5;
    localparam int STB_FNUMHI = 6;
    localparam int STB_FBCON  = 7;
    localparam int STB_RHY    = 8;
    localparam int NSTB       = 9;

    typedef struct packed {
        logic [NSTB-1:0] strobe;  // one-hot, zero for a discarded address
        logic            op;      // operator write: group/sub are meaningful
        logic            chan;    // channel write: ch is meaningful
        logic [3:0]      ch;
        logic [1:0]      group;
        logic [2:0]      sub;
    } wr_dec_t;

    function automatic wr_dec_t wr_decode(input logic [7:0] addr);
        wr_dec_t d;
        // NOTE: every field gets a default before the branches, so no path leaves a value unassigned.
        d        = '0;
        d.ch     = addr[3:0];
        d.group  = addr[4:3];
        d.sub    = addr[2:0];
        if (addr == ADDR_RHY) begin
            d.strobe[STB_RHY] = 1'b1;
        end else if (addr[4:3] != 2'd3 && addr[2:0] <= 3'd5) begin
            d.op = 1'b1;
            case (addr & 8'hE0)
                ADDR_MULT:   d.strobe[STB_MULT]   = 1'b1;
                ADDR_KSL_TL: d.strobe[STB_KSL_TL] = 1'b1;
                ADDR_AR_DR:  d.strobe[STB_AR_DR]  = 1'b1;
                ADDR_SL_RR:  d.strobe[STB_SL_RR]  = 1'b1;
                ADDR_WAV:    d.strobe[STB_WAV]    = 1'b1;
                default:     d.op                 = 1'b0;
            endcase
        end
        // Channel ranges live at 0xA0-0xCF, disjoint from the operator bases above.
        if (!d.op && addr != ADDR_RHY && addr[3:0] <= 4'd8) begin
            d.chan = 1'b1;
            case (addr & 8'hF0)
                ADDR_FNUMLO: d.strobe[STB_FNUMLO] = 1'b1;
                ADDR_FNUMHI: d.strobe[STB_FNUMHI] = 1'b1;
                ADDR_FBCON:  d.strobe[STB_FBCON]  = 1'b1;
                default:     d.chan               = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/jtopl_wr_fifo.sv
// Show-ahead FIFO holding pending {addr,data} register writes.
// dout always presents the oldest entry while empty is low.
module jtopl_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array carries no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jtopl_wr_sched.sv
// Serialises register writes toward the OPL register block: queues requests,
// decodes each address and holds its update strobe for HOLD slot-rate cen pulses.
module jtopl_wr_sched
    import jtopl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic [7:0] din,
    output logic       write,
    output logic [3:0] sel_ch,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic       up_rhy,
    output logic [7:0] rhy_data
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [NSTB-1:0]        strobe;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0]            fifo_dout;
    logic                   push;
    logic                   pop;
    wr_dec_t                head_dec;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);
    assign head_dec  = wr_decode(fifo_dout[15:8]);

    jtopl_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({req_addr, req_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            strobe    <= '0;
            write     <= 1'b0;
            din       <= '0;
            sel_ch    <= '0;
            sel_group <= '0;
            sel_sub   <= '0;
            rhy_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The popped head is decoded here so its outputs are already valid during LOAD.
                    if (!fifo_empty) begin
                        state <= ST_LOAD;
                        if (head_dec.strobe != '0) begin
                            strobe <= head_dec.strobe;
                            write  <= 1'b1;
                            din    <= fifo_dout[7:0];
                            if (head_dec.strobe[STB_RHY]) rhy_data <= fifo_dout[7:0];
                            if (head_dec.op) begin
                                sel_group <= head_dec.group;
                                sel_sub   <= head_dec.sub;
                            end
                            if (head_dec.chan) sel_ch <= head_dec.ch;
                        end
                    end
                end
                ST_LOAD: begin
                    write <= 1'b0;
                    if (strobe != '0 && !strobe[STB_RHY]) begin
                        state <= ST_HOLD;
                        cnt   <= CW'(HOLD - 1);
                    end else begin
                        state  <= ST_IDLE;
                        strobe <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cen) begin
                        if (cnt == '0) begin
                            strobe <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    strobe <= '0;
                    write  <= 1'b0;
                end
            endcase
        end
    end

    assign up_mult   = strobe[STB_MULT];
    assign up_ksl_tl = strobe[STB_KSL_TL];
    assign up_ar_dr  = strobe[STB_AR_DR];
    assign up_sl_rr  = strobe[STB_SL_RR];
    assign up_wav    = strobe[STB_WAV];
    assign up_fnumlo = strobe[STB_FNUMLO];
    assign up_fnumhi = strobe[STB_FNUMHI];
    assign up_fbcon  = strobe[STB_FBCON];
    assign up_rhy    = strobe[STB_RHY];

endmodule

// File: tb/tb_jtopl_wr_sched.sv
// Self-checking bench for jtopl_wr_sched: directed scenarios plus randomized
// traffic, compared against an address-range reference model and a write queue.
module tb_jtopl_wr_sched;

    localparam int DEPTH = 4;
    localparam int HOLD  = 21;
    localparam int OP_BASE [5] = '{32'h20, 32'h40, 32'h60, 32'h80, 32'hE0};
    localparam int CH_BASE [3] = '{32'hA0, 32'hB0, 32'hC0};

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, busy, write;
    logic [7:0] din, rhy_data;
    logic [3:0] sel_ch;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
    logic       up_fnumlo, up_fnumhi, up_fbcon, up_rhy;
    logic [8:0] strobes;

    int n_checks = 0;
    int n_errors = 0;
    int cen_mode = 0;
    int cen_phase = 0;

    req_t       exp_q[$];
    int         n_writes = 0;
    int         hold_cnt = 0;
    int         exp_hold = 0;
    logic       active = 1'b0;
    logic [8:0] cur_s = '0;
    logic [7:0] cur_d = '0;

    jtopl_wr_sched #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .din       (din),
        .write     (write),
        .sel_ch    (sel_ch),
        .sel_group (sel_group),
        .sel_sub   (sel_sub),
        .up_mult   (up_mult),
        .up_ksl_tl (up_ksl_tl),
        .up_ar_dr  (up_ar_dr),
        .up_sl_rr  (up_sl_rr),
        .up_wav    (up_wav),
        .up_fnumlo (up_fnumlo),
        .up_fnumhi (up_fnumhi),
        .up_fbcon  (up_fbcon),
        .up_rhy    (up_rhy),
        .rhy_data  (rhy_data)
    );

    assign strobes = {up_rhy, up_fbcon, up_fnumhi, up_fnumlo,
                      up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode from the register map: kind 0 none, 1 operator, 2 channel, 3 rhythm.
    function automatic void ref_decode(input logic [7:0] a, output logic [8:0] s,
                                       output int grp, output int sub, output int ch, output int kind);
        int ai;
        ai = int'(a);
        s = '0; grp = 0; sub = 0; ch = 0; kind = 0;
        if (ai == 32'hBD) begin
            s = 9'h100;
            kind = 3;
            return;
        end
        for (int i = 0; i < 5; i++) begin
            int off;
            off = ai - OP_BASE[i];
            if (off >= 0 && off <= 21 && (off % 8) <= 5 && (off / 8) != 3) begin
                s = 9'(1 << i); grp = off / 8; sub = off % 8; kind = 1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            int off;
            off = ai - CH_BASE[i];
            if (off >= 0 && off <= 8) begin
                s = 9'(1 << (5 + i)); ch = off; kind = 2;
            end
        end
    endfunction

    // cen changes 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (cen_mode == 0) begin
            cen = (cen_phase == 3);
            cen_phase = (cen_phase + 1) % 4;
        end else begin
            cen = ($urandom_range(0, 2) == 0);
        end
    end

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) exp_q.push_back('{a: req_addr, d: req_data});
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
            hold_cnt = 0;
            exp_q.delete();
        end else begin
            check("onehot", ($countones(strobes) > 1), 0);
            if (write) begin
                req_t       r;
                logic [8:0] s;
                int         grp, sub, ch, kind;
                logic       found;
                found = 1'b0;
                kind = 0; s = '0; grp = 0; sub = 0; ch = 0;
                check("overlap", active, 0);
                while (exp_q.size() > 0 && !found) begin
                    r = exp_q.pop_front();
                    ref_decode(r.a, s, grp, sub, ch, kind);
                    if (kind != 0) found = 1'b1;
                end
                n_writes++;
                if (!found) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("strobe", strobes, s);
                    check("din", din, r.d);
                    if (kind == 1) begin
                        check("sel_group", sel_group, grp);
                        check("sel_sub", sel_sub, sub);
                    end
                    if (kind == 2) check("sel_ch", sel_ch, ch);
                    if (kind == 3) check("rhy_data", rhy_data, r.d);
                end
                active = 1'b1;
                hold_cnt = 0;
                exp_hold = (kind == 3) ? 0 : HOLD;
                cur_s = s;
                cur_d = r.d;
            end else if (active) begin
                if (strobes == '0) begin
                    check("hold_len", hold_cnt, exp_hold);
                    check("din_stable", din, cur_d);
                    active = 1'b0;
                end else begin
                    check("strobe_stable", strobes, cur_s);
                    if (cen) hold_cnt++;
                end
            end else begin
                check("stray_strobe", strobes, 0);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        req_addr = a;
        req_data = d;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", (n >= 2000), 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (n_writes < target && n < 2000);
        check("write_timeout", (n_writes < target), 0);
    endtask

    initial begin
        int w0, first_full, valid_left;
        logic [7:0] six_addr [6];
        six_addr = '{8'h20, 8'h41, 8'hA3, 8'h62, 8'hC0, 8'hE5};

        repeat (3) @(negedge clk);
        #1;
        check("rst_write", write, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_strobes", strobes, 0);
        check("post_rst_din", din, 0);
        check("post_rst_rhy", rhy_data, 0);

        // Operator write with cen every 4 clk.
        cen_mode = 0;
        send(8'h23, 8'h41);
        wait_writes(1);
        check("mult_sel_group", sel_group, 0);
        check("mult_sel_sub", sel_sub, 3);
        check("mult_up", up_mult, 1);
        wait_idle(500);

        // Channel write followed by an out-of-range channel, then a lone discard.
        send(8'hB8, 8'h2A);
        send(8'hC9, 8'h11);
        wait_idle(500);
        w0 = n_writes;
        send(8'hC9, 8'h11);
        check("discard_busy_q", busy, 1);
        @(negedge clk);
        check("discard_busy_load", busy, 1);
        @(negedge clk);
        check("discard_busy_fall", busy, 0);
        check("discard_no_write", n_writes, w0);

        // FIFO fill with DEPTH 4 and a held request stream.
        wait_idle(500);
        first_full = 0;
        w0 = n_writes;
        for (int i = 0; i < 6; i++) begin
            send(six_addr[i], 8'(8'h10 + i));
            if (!req_ready && first_full == 0) first_full = i + 1;
        end
        check("full_after", first_full, 5);
        wait_idle(4000);
        check("six_issued", n_writes - w0, 6);

        // Rhythm write queued behind an operator hold.
        send(8'h45, 8'h07);
        wait_writes(n_writes + 1);
        send(8'hBD, 8'h3F);
        wait_idle(1000);
        check("rhy_final", rhy_data, 8'h3F);

        // Reset in the middle of a hold with two writes queued.
        send(8'h45, 8'h5A);
        wait_writes(n_writes + 1);
        send(8'h61, 8'h01);
        send(8'hA2, 8'h02);
        begin
            int n;
            n = 0;
            while (hold_cnt < 10 && n < 2000) begin
                @(negedge clk);
                #2;
                n++;
            end
            check("hold10_timeout", (hold_cnt < 10), 0);
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", strobes, 0);
        check("rst_mid_din", din, 0);
        check("rst_mid_sel", {sel_ch, sel_group, sel_sub}, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = n_writes;
        repeat (100) @(negedge clk);
        #1;
        check("rst_no_issue", n_writes, w0);
        check("rst_idle_busy", busy, 0);

        // Sub 6 and group 3 addresses are dropped.
        w0 = n_writes;
        send(8'h26, 8'h55);
        send(8'h38, 8'h66);
        wait_idle(200);
        check("invalid_dropped", n_writes, w0);

        // Randomized traffic with random cen.
        cen_mode = 1;
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [7:0] a;
            r = $urandom_range(0, 9);
            if (r < 4)      a = 8'(OP_BASE[$urandom_range(0, 4)] + $urandom_range(0, 21));
            else if (r < 7) a = 8'(CH_BASE[$urandom_range(0, 2)] + $urandom_range(0, 9));
            else if (r < 8) a = 8'hBD;
            else            a = 8'($urandom_range(0, 255));
            send(a, 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(8000);
        valid_left = 0;
        foreach (exp_q[i]) begin
            logic [8:0] s;
            int grp, sub, ch, kind;
            ref_decode(exp_q[i].a, s, grp, sub, ch, kind);
            if (kind != 0) valid_left++;
        end
        check("queue_drained", valid_left, 0);
        check("monitor_idle", active, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
